// File: rtl/mc_control_if.sv
// mc_control_if: decode/handshake/debug inputs and datapath control outputs of the multicycle controller
interface mc_control_if;
  logic [5:0] opcode, func;
  logic zero, mem_ready, debug, step;
  logic PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUSel;
  logic [3:0] curr_state;
  logic halted, illegal;
  modport master (
    input opcode, func, zero, mem_ready, debug, step,
    output PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
    output PCSource, ALUSrcB, ALUSel, curr_state, halted, illegal
  );
  modport slave (
    output opcode, func, zero, mem_ready, debug, step,
    input PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
    input PCSource, ALUSrcB, ALUSel, curr_state, halted, illegal
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-style control FSM with memory handshake and debug halt/single-step
module mc_control #(
  parameter bit MEM_HS = 1'b1,
  parameter bit EXT_ISA = 1'b1
) (
  input logic clk,
  input logic rst,
  mc_control_if.master bus
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10,
    IMMWB = 4'd11, HALT = 4'd12;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000, ALU_OR = 3'b001,
    ALU_SLT = 3'b111;
  logic [3:0] state_q, state_d, nxt;
  logic boot_q, boot_d, rdy, boot_halt, is_mem, is_addi;
  logic pc_en, mem_read, mem_write, ir_write, reg_write;
  logic [2:0] r_sel;
  always_comb begin
    rdy = !MEM_HS || bus.mem_ready;
    boot_halt = boot_q && bus.debug;
    is_mem = bus.opcode == OP_LW || bus.opcode == OP_SW;
    is_addi = EXT_ISA && bus.opcode == OP_ADDI;
    boot_d = 1'b0;
    case (state_q)
      FETCH: nxt = boot_halt ? HALT : rdy ? DECODE : FETCH;
      DECODE: nxt = is_mem ? MEMADR : bus.opcode == OP_R ? EXEC : bus.opcode == OP_BEQ ? BRANCH :
        bus.opcode == OP_J ? JUMP : is_addi ? ADDIEX : FETCH;
      MEMADR: nxt = bus.opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD: nxt = rdy ? MEMWB : MEMRD;
      MEMWR: nxt = rdy ? FETCH : MEMWR;
      EXEC: nxt = ALUWB;
      ADDIEX: nxt = IMMWB;
      HALT: nxt = (!bus.debug || bus.step) ? FETCH : HALT;
      default: nxt = FETCH;
    endcase
    // an instruction boundary under debug parks in HALT; leaving HALT is never redirected
    state_d = (nxt == FETCH && state_q != FETCH && state_q != HALT && bus.debug) ? HALT : nxt;
  end
  always_comb begin
    r_sel = bus.func == 6'b100010 ? ALU_SUB : bus.func == 6'b100100 ? ALU_AND :
      bus.func == 6'b100101 ? ALU_OR : bus.func == 6'b101010 ? ALU_SLT : ALU_ADD;
    pc_en = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    bus.IorD = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegDst = 1'b0;
    bus.ALUSrcA = 1'b0;
    bus.PCSource = 2'b00;
    bus.ALUSrcB = 2'b00;
    bus.ALUSel = 3'b000;
    case (state_q)
      FETCH: begin
        mem_read = !boot_halt;
        ir_write = rdy && !boot_halt;
        pc_en = rdy && !boot_halt;
        bus.ALUSrcB = 2'b01;
        bus.ALUSel = ALU_ADD;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.ALUSel = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUSel = ALU_ADD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        bus.IorD = 1'b1;
      end
      MEMWB: begin
        reg_write = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        bus.IorD = 1'b1;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSel = r_sel;
      end
      ALUWB: begin
        reg_write = 1'b1;
        bus.RegDst = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSel = ALU_SUB;
        bus.PCSource = 2'b01;
        pc_en = bus.zero;
      end
      JUMP: begin
        bus.PCSource = 2'b10;
        pc_en = 1'b1;
      end
      IMMWB: reg_write = 1'b1;
      default: ;
    endcase
  end
  // strobes are masked by the reset input itself so they drop without waiting for a clock
  assign bus.PCEn = pc_en && rst;
  assign bus.MemRead = mem_read && rst;
  assign bus.MemWrite = mem_write && rst;
  assign bus.IRWrite = ir_write && rst;
  assign bus.RegWrite = reg_write && rst;
  assign bus.curr_state = state_q;
  assign bus.halted = state_q == HALT;
  assign bus.illegal = state_q == DECODE && nxt == FETCH;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FETCH;
      boot_q <= 1'b1;
    end else begin
      state_q <= state_d;
      boot_q <= boot_d;
    end
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_HS, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, memory treated as single-cycle.
REQ-002 Parameter EXT_ISA, default 1, meaning: 1 = addi (opcode 001000) supported; 0 = addi decodes as illegal.
REQ-003 clk  in  1  rising-edge clock, sole clock domain.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 opcode  in  6  IR[31:26].
REQ-006 func  in  6  IR[5:0].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory access completes this cycle.
REQ-009 debug  in  1  halt request.
REQ-010 step  in  1  single-step request, sampled only in HALT.
REQ-011 PCEn, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls.
REQ-012 PCSource, ALUSrcB  out  2 each; ALUSel  out  3 (010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-013 curr_state  out  4  state register; halted  out  1; illegal  out  1.

Function
REQ-014 States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, IMMWB 11, HALT 12; codes 13-15 SHALL go to FETCH next cycle.
REQ-015 Outputs SHALL be Moore (state only) except PCEn in BRANCH (=zero) and memory strobes gated by mem_ready (REQ-022); unlisted outputs 0.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUSel=add, PCSource=00, IRWrite=PCEn=1 (subject to REQ-022); next DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, add; next: lw/sw(100011/101011)->MEMADR, R(000000)->EXEC, beq(000100)->BRANCH, j(000010)->JUMP, addi->ADDIEX if EXT_ISA else illegal.
REQ-018 Illegal opcode in DECODE: illegal=1 for that one cycle, next FETCH, no register/memory write.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, add; lw->MEMRD, sw->MEMWR. MEMRD: MemRead=1, IorD=1; ->MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH. MEMWR: MemWrite=1, IorD=1; ->FETCH.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00, ALUSel from func (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other add); ->ALUWB. ALUWB: RegDst=1, RegWrite=1; ->FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PCEn=zero; ->FETCH. JUMP: PCSource=10, PCEn=1; ->FETCH. ADDIEX: ALUSrcA=1, ALUSrcB=10, add; ->IMMWB. IMMWB: RegDst=0, RegWrite=1; ->FETCH.
REQ-022 MEM_HS=1: FETCH, MEMRD, MEMWR SHALL hold state while mem_ready=0 with MemRead/MemWrite/IorD held; IRWrite, PCEn (FETCH) asserted only in the cycle mem_ready=1; MemWrite asserted every waiting cycle of MEMWR, advance on mem_ready=1.
REQ-023 Debug: on entry to FETCH (from any state, or reset release) with debug=1, FSM SHALL instead enter HALT; halted=1 in HALT, all strobes 0.
REQ-024 HALT: debug=0 -> FETCH; step=1 -> FETCH executing exactly one instruction, then HALT again if debug still 1; step and debug=0 together -> FETCH.
REQ-025 debug raised mid-instruction SHALL not abort it; halt takes effect at next instruction boundary.

Reset
REQ-026 rst=0 SHALL asynchronously set curr_state=FETCH (0), halted=0, illegal=0, and force PCEn, IRWrite, RegWrite, MemRead, MemWrite to 0 combinationally while rst=0.
REQ-027 Reset mid-instruction (including mid-wait) SHALL abandon it; first post-release cycle is FETCH, or HALT if debug=1.

Verification
REQ-028 MEM_HS=0, lw (100011): state sequence 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4.
REQ-029 MEM_HS=1, mem_ready low 3 cycles in FETCH: state stays 0 four cycles, IRWrite=PCEn=1 only in 4th.
REQ-030 beq with zero=0 then zero=1: PCEn=0 then 1 in state 8; PCSource=01 both.
REQ-031 EXT_ISA=0, opcode 001000: illegal=1 one cycle in state 1, next state 0, RegWrite never 1.
REQ-032 debug=1 during EXEC of add: completes 6,7, then state 12, halted=1; step pulse -> one R-type (0,1,6,7) -> 12.
REQ-033 rst low during state 5 with MemWrite=1: MemWrite drops immediately, curr_state=0; after release fetch restarts.
